// File: rtl/haru_fifo_pkg.sv
// haru_fifo_pkg: shared FIFO defaults and the pointer/count width helper.
package haru_fifo_pkg;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_MARGIN = 2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sink_fifo_mem.sv
// sink_fifo_mem: flop-array storage with one write port and one combinational read port.
module sink_fifo_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/accel_sink_fifo.sv
// accel_sink_fifo: FWFT sink buffer between the packet filter and an accelerator core.
// Sticky overflow detection is built only when ACCEL_SINK_FIFO_OVERFLOW_EN is defined.
module accel_sink_fifo
  import haru_fifo_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH         = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_MARGIN = DEFAULT_MARGIN
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush_in,
  input  logic                           fifo_wren_in,
  input  logic [FIFO_DATA_WIDTH-1:0]     fifo_data_in,
  output logic                           fifo_full_out,
  output logic                           almost_full_out,
  output logic [FIFO_DATA_WIDTH-1:0]     M_AXIS_tdata_out,
  output logic                           M_AXIS_tvalid_out,
  input  logic                           M_AXIS_tready_in,
  output logic [ptr_w(FIFO_DEPTH):0]     count_out,
  output logic                           overflow_out
);
  localparam int AW = ptr_w(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(FIFO_DEPTH - ALMOST_FULL_MARGIN);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr, rd;
  assign fifo_full_out     = count == FULL_CNT;
  assign almost_full_out   = count >= AF_CNT;
  assign M_AXIS_tvalid_out = count != '0;
  assign count_out         = count;
  assign wr = fifo_wren_in && !fifo_full_out && !flush_in;
  assign rd = M_AXIS_tvalid_out && M_AXIS_tready_in;
  sink_fifo_mem #(.W(FIFO_DATA_WIDTH), .DEPTH(FIFO_DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (fifo_data_in),
    .raddr (rd_ptr),
    .rdata (M_AXIS_tdata_out)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= (wr && !rd) ? count + (AW+1)'(1) : (rd && !wr) ? count - (AW+1)'(1) : count;
    end
`ifdef ACCEL_SINK_FIFO_OVERFLOW_EN
  logic ovf;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ovf <= 1'b0;
    else if (flush_in) ovf <= 1'b0;
    else if (fifo_wren_in && fifo_full_out) ovf <= 1'b1;
  assign overflow_out = ovf;
`else
  assign overflow_out = 1'b0;
`endif
endmodule
